// File: rtl/truth_table_sweeper.sv
// -----------------------------------------------------------------------------
// truth_table_sweeper
//
// This block sweeps the three switch stimulus lines (p1, p2, p3) through all
// eight combinations. For each row it waits for the implementations under test
// to settle and then samples their result lines. It records res[0] as the truth
// table, and it flags every row where the result lines do not all agree.
//
// Optional feature: when the macro SWEEP_STOP_ON_MISMATCH_EN is defined, the
// sweep ends at the first row with a mismatch. When it is undefined, the block
// always sweeps all eight rows.
//
// Parameters:
//   SETTLE  cycles each combination is driven before it is sampled (min 1)
//   N_OUT   number of result lines compared per row
//
// Ports:
//   clk_i             system clock
//   reset_i           synchronous, active-high reset
//   start_i           sweep request, sampled only while idle
//   res_i             result lines from the implementations under test
//   p1_o/p2_o/p3_o    stimulus bits, row index MSB..LSB
//   busy_o            high from sweep acceptance through the DONE cycle
//   done_o            one-cycle pulse at end of sweep
//   pass_o            no mismatching row in the last sweep
//   truth_o           truth_o[r] = res_i[0] sampled on row r
//   mismatch_rows_o   bit r set if the result lines disagreed on row r
//   fail_row_o        first mismatching row, 0 if none
//
// States:
//   IDLE   | stimulus 000, waiting for start
//   DRIVE  | stimulus = row, settle counter running
//   SAMPLE | capture results for the current row
//   DONE   | one-cycle done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module truth_table_sweeper #(
    parameter int SETTLE = 2,
    parameter int N_OUT  = 6
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [N_OUT-1:0] res_i,
    output logic             p1_o,
    output logic             p2_o,
    output logic             p3_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             pass_o,
    output logic [7:0]       truth_o,
    output logic [7:0]       mismatch_rows_o,
    output logic [2:0]       fail_row_o
);

    // A SETTLE value below 1 is clamped to 1, so DRIVE always lasts at least one cycle.
    localparam int              SETTLE_E = (SETTLE < 1) ? 1 : SETTLE;
    localparam int              CW       = (SETTLE_E > 1) ? $clog2(SETTLE_E) : 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'(SETTLE_E - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t          state_q;
    logic [2:0]      row_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      stim_q;
    logic            busy_q;
    logic            done_q;
    logic            pass_q;
    logic [7:0]      truth_q;
    logic [7:0]      mism_q;
    logic [2:0]      fail_q;

    logic            row_mism;
    logic            first_mism;
    logic            stop_now;
    logic [7:0]      truth_d;
    logic [7:0]      mism_d;

    // A row agrees only if every result line has the same value.
    assign row_mism   = (res_i != '0) && (res_i != '1);
    assign first_mism = row_mism && (mism_q == 8'h00);

`ifdef SWEEP_STOP_ON_MISMATCH_EN
    assign stop_now = row_mism || (row_q == 3'd7);
`else
    assign stop_now = (row_q == 3'd7);
`endif

    always_comb begin
        truth_d        = truth_q;
        truth_d[row_q] = res_i[0];
        mism_d         = mism_q;
        if (row_mism) begin
            mism_d[row_q] = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            row_q   <= 3'd0;
            cnt_q   <= '0;
            stim_q  <= 3'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            truth_q <= 8'h00;
            mism_q  <= 8'h00;
            fail_q  <= 3'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    stim_q <= 3'd0;
                    if (start_i) begin
                        state_q <= DRIVE;
                        row_q   <= 3'd0;
                        cnt_q   <= CNT_LOAD;
                        busy_q  <= 1'b1;
                        truth_q <= 8'h00;
                        mism_q  <= 8'h00;
                        fail_q  <= 3'd0;
                        pass_q  <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (cnt_q == '0) begin
                        state_q <= SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - CW'(1);
                    end
                end
                SAMPLE: begin
                    truth_q <= truth_d;
                    mism_q  <= mism_d;
                    if (first_mism) begin
                        fail_q <= row_q;
                    end
                    if (stop_now) begin
                        // Compute pass from the updated vector so that it is
                        // already valid in the same cycle as done.
                        state_q <= DONE;
                        done_q  <= 1'b1;
                        pass_q  <= (mism_d == 8'h00);
                        stim_q  <= 3'd0;
                    end else begin
                        state_q <= DRIVE;
                        row_q   <= row_q + 3'd1;
                        stim_q  <= row_q + 3'd1;
                        cnt_q   <= CNT_LOAD;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign p1_o            = stim_q[2];
    assign p2_o            = stim_q[1];
    assign p3_o            = stim_q[0];
    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign pass_o          = pass_q;
    assign truth_o         = truth_q;
    assign mismatch_rows_o = mism_q;
    assign fail_row_o      = fail_q;

endmodule

// File: doc/truth_table_sweeper.md
Name: truth_table_sweeper

Overview:
- Hardware counterpart of the lab's truth-table bench: drives the three switch inputs (p1, p2, p3) of the combinational implementations through all 8 combinations, then reads back their LED outputs.
- Checks that all implementations agree on each row and records the resulting truth table.
- Sits between the board start button and the six gate-level/operator implementations under test; results go to LEDs or the display.

Parameters:
- SETTLE, 2, cycles each input combination is held before results are sampled; minimum 1, values below 1 behave as 1
- N_OUT, 6, number of result lines compared per row

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request a sweep; sampled only in IDLE
- res  input  N_OUT  result lines from the implementations under test (led1..led6)
- p1  output  1  stimulus bit, MSB of row index
- p2  output  1  stimulus bit, middle bit of row index
- p3  output  1  stimulus bit, LSB of row index
- busy  output  1  high from sweep acceptance through DONE
- done  output  1  one-cycle pulse at end of sweep
- pass  output  1  1 = no mismatching row in last sweep
- truth  output  8  truth[r] = res[0] sampled on row r
- mismatch_rows  output  8  bit r set if res lines disagreed on row r
- fail_row  output  3  index of first mismatching row; 0 if none

Behaviour:
- Clock and reset: single clock clk; reset synchronous, active-high. Reset is sampled on the clk edge and takes priority over everything.
- Reset values: p1 = p2 = p3 = 0, busy = 0, done = 0, pass = 0, truth = 0, mismatch_rows = 0, fail_row = 0, state IDLE, row counter 0, settle counter 0.
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
- IDLE:
  - Stimulus outputs held at 000.
  - start = 1 → next cycle enters DRIVE with row = 0.
  - On that transition: truth, mismatch_rows, fail_row and pass are cleared; busy goes 1.
- DRIVE:
  - {p1,p2,p3} = row.
  - Remains exactly SETTLE cycles (counter 0..SETTLE-1), then → SAMPLE.
- SAMPLE (one cycle, stimulus unchanged):
  - truth[row] <= res[0].
  - mismatch_rows[row] <= 1 unless res is all-zeros or all-ones.
  - If this is the first mismatch of the sweep, fail_row <= row.
  - row == 7 → DONE; otherwise row+1 → DRIVE with settle counter reset.
- DONE (one cycle): done = 1; pass <= (mismatch_rows == 0), including the row-7 result. Then → IDLE; busy = 0 in IDLE.
- Latency: start accepted at cycle 0 → done high at cycle 8*(SETTLE+1)+1. This is 25 for SETTLE = 2.
- start while busy is ignored.
- start held high continuously → a new sweep is accepted in the first IDLE cycle after DONE.
- Results (truth, mismatch_rows, fail_row, pass) hold stable after done until the next accepted start or reset.
- Reset mid-sweep: the next cycle shows reset values; the partial sweep is discarded and no done pulse is issued.
- Row counter is 3 bits; it never wraps inside a sweep, because the 7 → DONE transition precedes any increment.

Optional Feature:
- Macro: SWEEP_STOP_ON_MISMATCH_EN.
- Defined: a mismatch detected in SAMPLE sends the FSM straight to DONE. Rows after the failing row keep truth = 0 and mismatch = 0. done then occurs (fail_row+1)*(SETTLE+1)+1 cycles after start.
- Undefined: all 8 rows are always swept, as described above.

Test Plan:
1. SETTLE=2; all 6 res lines = (p1&p2)|p3 → done at cycle 25, truth = 8'hEA, mismatch_rows = 8'h00, fail_row = 0, pass = 1.
2. Same as 1, but res[4] inverted only when {p1,p2,p3} = 101 → mismatch_rows = 8'h20, fail_row = 5, pass = 0, truth = 8'hEA.
3. Pulse start again at cycle 10 of a sweep, then hold start high through two sweeps → mid-sweep pulse ignored (done still at 25); second sweep accepted in the IDLE cycle after DONE; done again 25 cycles later.
4. Assert reset for one cycle while row = 3 → next cycle busy = 0, {p1,p2,p3} = 000, truth = 0, no done pulse; a following start produces a full, correct sweep.
5. SWEEP_STOP_ON_MISMATCH_EN defined, mismatch injected on row 2, SETTLE=2 → done at cycle 10, fail_row = 2, mismatch_rows = 8'h04, truth[7:3] = 0, pass = 0.
6. Sweep rows 0..7 in order → {p1,p2,p3} steps 000 → 111 in order, each value held exactly SETTLE+1 = 3 cycles.
